rr_grant4: RTL and testbench

- Four-requester round-robin arbiter producing a registered one-hot grant (gnt0..gnt3).
- Sits directly upstream of the team's 4-to-2 one-hot encoder. gnt0..gnt3 wire straight to its i0..i3, so the encoder always sees a legal one-hot or all-zero pattern.
- Owner holds the grant while requesting, bounded by MAX_HOLD cycles, then is preempted if others wait.

---
 rtl/rr_grant4.sv | 118 +++++++++++
 tb/tb_rr_grant4.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant4.sv
// Four-requester round-robin arbiter with bounded hold time and a registered one-hot grant.
// Latency: a grant appears the cycle after the request is sampled; a handoff happens on a single edge.
// Backpressure: none; the owner keeps the grant while its request is high, for at most MAX_HOLD cycles under contention.
module rr_grant4 #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   input  logic req2,
   input  logic req3,
   output logic gnt0,
   output logic gnt1,
   output logic gnt2,
   output logic gnt3,
   output logic gnt_valid,
   output logic preempt
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state, state_nxt;
   logic [1:0]       ptr, ptr_nxt;
   logic [1:0]       owner, owner_nxt;
   logic [1:0]       owner_inc;
   logic [CNT_W-1:0] hold_cnt, hold_nxt;
   logic [3:0]       req;
   logic [3:0]       others;
   logic [3:0]       gnt_nxt;
   logic             preempt_nxt;

   assign req       = {req3, req2, req1, req0};
   assign owner_inc = owner + 2'd1;

   // First asserted request scanning cyclically upward from index 'from'.
   // Scanning from the far end down lets the nearest hit win.
   function automatic logic [1:0] search(input logic [1:0] from, input logic [3:0] r);
      logic [1:0] idx;
      search = from;
      for (int i = 3; i >= 0; i--) begin
         idx = from + 2'(i);
         if (r[idx]) search = idx;
      end
   endfunction

   // Arbitration state: mode, rotation pointer, current owner and hold counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= 2'd0;
         owner    <= 2'd0;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         owner    <= owner_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   // Next-state decision: new grant from idle, release handoff, hold count, timeout preemption.
   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      owner_nxt   = owner;
      hold_nxt    = hold_cnt;
      preempt_nxt = 1'b0;
      others      = req & ~(4'b0001 << owner);
      case (state)
         IDLE: begin
            if (|req) begin
               owner_nxt = search(ptr, req);
               hold_nxt  = '0;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (!req[owner]) begin
               // Release: pointer moves past the old owner, hand off directly if anyone waits.
               ptr_nxt  = owner_inc;
               hold_nxt = '0;
               if (|req) owner_nxt = search(owner_inc, req);
               else      state_nxt = IDLE;
            end else if (hold_cnt < HOLD_LAST) begin
               hold_nxt = hold_cnt + 1'b1;
            end else begin
               // Timeout: the owner sits last in the scan from owner+1, so any waiter wins.
               hold_nxt = '0;
               if (|others) begin
                  ptr_nxt     = owner_inc;
                  owner_nxt   = search(owner_inc, req);
                  preempt_nxt = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      gnt_nxt = (state_nxt == GRANT) ? (4'b0001 << owner_nxt) : 4'b0000;
   end

   // Registered outputs, so the downstream encoder only ever sees one-hot or zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {gnt3, gnt2, gnt1, gnt0} <= 4'b0000;
         gnt_valid                <= 1'b0;
         preempt                  <= 1'b0;
      end else begin
         {gnt3, gnt2, gnt1, gnt0} <= gnt_nxt;
         gnt_valid                <= |gnt_nxt;
         preempt                  <= preempt_nxt;
      end
   end

endmodule

// File: tb/tb_rr_grant4.sv
// Bench for rr_grant4: directed scenarios plus randomized traffic against a behavioural model.
module tb_rr_grant4;

   localparam int MAX_HOLD = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b0000;
   logic       gnt0, gnt1, gnt2, gnt3, gnt_valid, preempt;
   logic [3:0] dut_gnt;

   int tests = 0;
   int fails = 0;

   // Behavioural model: owner is -1 when nobody holds the grant.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_hold  = 0;
   bit m_pre   = 0;

   assign dut_gnt = {gnt3, gnt2, gnt1, gnt0};

   rr_grant4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req[0]), .req1(req[1]), .req2(req[2]), .req3(req[3]),
      .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2), .gnt3(gnt3),
      .gnt_valid(gnt_valid), .preempt(preempt)
   );

   always #5 clk = ~clk;

   function automatic int find_from(input int p, input logic [3:0] r);
      for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   function automatic logic [3:0] model_gnt();
      if (m_owner < 0) return 4'b0000;
      return 4'(1 << m_owner);
   endfunction

   task automatic model_reset();
      m_owner = -1; m_ptr = 0; m_hold = 0; m_pre = 0;
   endtask

   // Advance the model by one clock edge given the sampled requests.
   task automatic model_edge(input logic [3:0] r);
      m_pre = 0;
      if (m_owner < 0) begin
         if (r != 0) begin m_owner = find_from(m_ptr, r); m_hold = 0; end
      end else if (!r[m_owner]) begin
         m_ptr   = (m_owner + 1) % 4;
         m_owner = find_from(m_ptr, r);
         m_hold  = 0;
      end else if (m_hold < MAX_HOLD - 1) begin
         m_hold++;
      end else begin
         m_hold = 0;
         if ((r & ~(4'(1 << m_owner))) != 0) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = find_from(m_ptr, r);
            m_pre   = 1;
         end
      end
   endtask

   // Drive requests for one cycle, take the edge, sample 1 time unit later.
   task automatic cyc(input logic [3:0] r);
      req = r;
      @(posedge clk);
      model_edge(r);
      #1;
   endtask

   task automatic apply_reset();
      req = 4'b0000;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      req = 4'b0000;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({dut_gnt, gnt_valid, preempt} !== 6'b0) begin
         fails++;
         $display("FAIL reset_hold: got gnt=%b v=%b p=%b, want all 0", dut_gnt, gnt_valid, preempt);
      end
      model_reset();
      rst_n = 1'b1;
      for (int t = 0; t < 5; t++) begin
         cyc(4'b0000);
         tests++;
         if ({dut_gnt, gnt_valid, preempt} !== 6'b0) begin
            fails++;
            $display("FAIL reset_idle t=%0d: got gnt=%b v=%b p=%b, want all 0", t, dut_gnt, gnt_valid, preempt);
         end
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      cyc(4'b0010);
      cyc(4'b0010);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({dut_gnt, gnt_valid, preempt} !== 6'b0) begin
         fails++;
         $display("FAIL async_reset: got gnt=%b v=%b p=%b, want all 0 before next edge", dut_gnt, gnt_valid, preempt);
      end
      apply_reset();
   endtask

   task automatic test_single();
      logic [3:0] exp;
      logic [1:0] enc;
      apply_reset();
      for (int t = 0; t < 6; t++) begin
         cyc((t < 4) ? 4'b0100 : 4'b0000);
         exp = (t + 1 >= 1 && t + 1 <= 4) ? 4'b0100 : 4'b0000;
         enc = {dut_gnt[3] | dut_gnt[2], dut_gnt[3] | dut_gnt[1]};
         tests++;
         if ({dut_gnt, gnt_valid, preempt} !== {exp, |exp, 1'b0}) begin
            fails++;
            $display("FAIL single cyc=%0d: got gnt=%b v=%b p=%b, want gnt=%b", t + 1, dut_gnt, gnt_valid, preempt, exp);
         end
         if (exp != 0) begin
            tests++;
            if (enc !== 2'b10) begin
               fails++;
               $display("FAIL single_enc cyc=%0d: got out=%b, want 10", t + 1, enc);
            end
         end
      end
   endtask

   task automatic test_fairness();
      logic [3:0] r;
      logic [3:0] exp;
      apply_reset();
      for (int t = 0; t < 10; t++) begin
         r = 4'b1111;
         if (t >= 1 && (t % 2) == 0) r[((t - 1) / 2) % 4] = 1'b0;
         cyc(r);
         exp = 4'(1 << ((t / 2) % 4));
         tests++;
         if ({dut_gnt, gnt_valid, preempt} !== {exp, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL fairness cyc=%0d: got gnt=%b v=%b p=%b, want gnt=%b v=1 p=0", t + 1, dut_gnt, gnt_valid, preempt, exp);
         end
      end
   endtask

   task automatic test_timeout();
      logic [3:0] exp;
      bit         expp;
      apply_reset();
      for (int k = 1; k <= 18; k++) begin
         cyc(4'b1010);
         exp  = (k <= 8) ? 4'b0010 : (k <= 16) ? 4'b1000 : 4'b0010;
         expp = (k == 9 || k == 17);
         tests++;
         if ({dut_gnt, gnt_valid, preempt} !== {exp, 1'b1, expp}) begin
            fails++;
            $display("FAIL timeout cyc=%0d: got gnt=%b p=%b, want gnt=%b p=%b", k, dut_gnt, preempt, exp, expp);
         end
      end
   endtask

   task automatic test_lone_owner();
      apply_reset();
      for (int k = 1; k <= 20; k++) begin
         cyc(4'b0001);
         tests++;
         if ({dut_gnt, gnt_valid, preempt} !== {4'b0001, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL lone_owner cyc=%0d: got gnt=%b v=%b p=%b, want gnt=0001 v=1 p=0", k, dut_gnt, gnt_valid, preempt);
         end
      end
   endtask

   task automatic test_ptr_wrap();
      logic [3:0] rs  [4];
      logic [3:0] exs [4];
      rs  = '{4'b1000, 4'b1101, 4'b0101, 4'b0100};
      exs = '{4'b1000, 4'b1000, 4'b0001, 4'b0100};
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         cyc(rs[k]);
         tests++;
         if ({dut_gnt, gnt_valid, preempt} !== {exs[k], 1'b1, 1'b0} || !$onehot0(dut_gnt)) begin
            fails++;
            $display("FAIL ptr_wrap step=%0d: got gnt=%b v=%b p=%b, want gnt=%b", k, dut_gnt, gnt_valid, preempt, exs[k]);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] r;
      apply_reset();
      r = 4'b0000;
      for (int t = 0; t < 2000; t++) begin
         for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) r[b] = ~r[b];
         cyc(r);
         tests++;
         if ({dut_gnt, gnt_valid, preempt} !== {model_gnt(), |model_gnt(), m_pre}) begin
            fails++;
            $display("FAIL random t=%0d req=%b: got gnt=%b v=%b p=%b, want gnt=%b p=%b",
                     t, r, dut_gnt, gnt_valid, preempt, model_gnt(), m_pre);
         end
         tests++;
         if (!$onehot0(dut_gnt) || gnt_valid !== (|dut_gnt)) begin
            fails++;
            $display("FAIL random_onehot t=%0d: got gnt=%b v=%b, want one-hot and v=OR", t, dut_gnt, gnt_valid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_async_reset();
      test_single();
      test_fairness();
      test_timeout();
      test_lone_owner();
      test_ptr_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
